// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_arbiter : two-requester front end for a shared combinational ALU,      |
// |               round-robin or fixed-priority grant, IDLE/EXEC/RESP flow.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req0_shamt,
  input  logic [4:0]  req1_shamt,
  output logic        resp0_valid,
  output logic        resp1_valid,
  input  logic        resp0_ready,
  input  logic        resp1_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] alu_rd1,
  output logic [31:0] alu_rd2,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shift_amt,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_last_grant;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_shamt;
  logic [31:0] r_resp_data;
  logic        r_resp_err;
  logic [15:0] r_op_count;

  logic w_idle;
  logic w_pick1;
  logic w_accept;
  logic w_resp_done;

  // Requester 1 wins when alone, or on contention when round-robin says it is its turn.
  assign w_idle      = (r_state == c_IDLE) && !rst;
  assign w_pick1     = req1_valid && (!req0_valid || ((RR_EN != 0) && !r_last_grant));
  assign req0_ready  = w_idle && req0_valid && !w_pick1;
  assign req1_ready  = w_idle && w_pick1;
  assign w_accept    = req0_ready || req1_ready;

  assign resp0_valid = !rst && (r_state == c_RESP) && !r_owner;
  assign resp1_valid = !rst && (r_state == c_RESP) && r_owner;
  assign w_resp_done = (r_state == c_RESP) && (r_owner ? resp1_ready : resp0_ready);

  assign busy          = !rst && (r_state != c_IDLE);
  assign resp_data     = r_resp_data;
  assign resp_err      = r_resp_err;
  assign op_count      = r_op_count;
  assign alu_rd1       = r_a;
  assign alu_rd2       = r_b;
  assign alu_op        = r_op;
  assign alu_shift_amt = r_shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_op         <= 4'd0;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_shamt      <= 5'd0;
      r_resp_data  <= 32'd0;
      r_resp_err   <= 1'b0;
      r_op_count   <= 16'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_owner <= w_pick1;
            r_op    <= w_pick1 ? req1_op    : req0_op;
            r_a     <= w_pick1 ? req1_a     : req0_a;
            r_b     <= w_pick1 ? req1_b     : req0_b;
            r_shamt <= w_pick1 ? req1_shamt : req0_shamt;
            r_state <= c_EXEC;
          end
        end
        c_EXEC: begin
          r_resp_data <= alu_result;
          r_resp_err  <= (r_op > 4'd8);
          r_state     <= c_RESP;
        end
        c_RESP: begin
          if (w_resp_done) begin
            r_last_grant <= r_owner;
            r_op_count   <= r_op_count + 16'd1;
            r_state      <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_arbiter : self-checking bench for alu_arbiter with a behavioural    |
// |                  ALU, transaction-level grant model and random traffic.    |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] alu_rd1, alu_rd2, alu_result;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shift_amt;
  logic        busy;
  logic [15:0] op_count;

  logic        f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
  logic        f_resp0_valid, f_resp1_valid, f_resp_err, f_busy;
  logic [31:0] f_resp_data, f_alu_rd1, f_alu_rd2, f_alu_result;
  logic [3:0]  f_alu_op;
  logic [4:0]  f_alu_shift_amt;
  logic [15:0] f_op_count;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_count;
  logic        m_last;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return $unsigned($signed(a) >>> sh);
      4'd7:    return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result   = alu_ref(alu_op, alu_rd1, alu_rd2, alu_shift_amt);
  always_comb f_alu_result = alu_ref(f_alu_op, f_alu_rd1, f_alu_rd2, f_alu_shift_amt);

  alu_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_rd1(alu_rd1), .alu_rd2(alu_rd2), .alu_op(alu_op), .alu_shift_amt(alu_shift_amt),
    .alu_result(alu_result), .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req1_valid(f_req1_valid),
    .req0_ready(f_req0_ready), .req1_ready(f_req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
    .resp0_valid(f_resp0_valid), .resp1_valid(f_resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp_data(f_resp_data), .resp_err(f_resp_err),
    .alu_rd1(f_alu_rd1), .alu_rd2(f_alu_rd2), .alu_op(f_alu_op), .alu_shift_amt(f_alu_shift_amt),
    .alu_result(f_alu_result), .busy(f_busy), .op_count(f_op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; f_req0_valid = 0; f_req1_valid = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req1_a = 0; req0_b = 0; req1_b = 0;
    req0_shamt = 0; req1_shamt = 0; resp0_ready = 0; resp1_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    repeat (2) tick();
    rst = 0;
    m_count = 16'd0;
    m_last  = 1'b1;
  endtask

  // Present one request, wait (bounded) for its ready, return just after the accepting edge.
  task automatic issue(input logic who, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    bit got = 0;
    if (who) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh; end
    else     begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh; end
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (who ? req1_ready : req0_ready) got = 1;
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    total++;
    if (!got) begin bad++; $display("FAIL issue_timeout: ready got 0 want 1 (requester %0d)", who); end
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
    tick(); tick();
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
    total++; if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {resp0_valid, resp1_valid, busy}); end
    total++; if ({resp_data, resp_err, op_count} !== 49'd0) begin bad++; $display("FAIL rst_data: got %h/%b/%h want 0", resp_data, resp_err, op_count); end
    total++; if ({alu_rd1, alu_rd2, alu_op, alu_shift_amt} !== 73'd0) begin bad++; $display("FAIL rst_alu: got %h %h %h %h want 0", alu_rd1, alu_rd2, alu_op, alu_shift_amt); end
    rst = 0;
    m_count = 16'd0;
    m_last  = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rst_first_grant: got %b want 10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_single();
    resp0_ready = 1;
    req0_valid = 1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; req0_shamt = 5'd0;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", req0_ready); end
    tick();
    req0_valid = 0;
    total++; if ({busy, resp0_valid} !== 2'b10) begin bad++; $display("FAIL single_exec: busy/valid got %b want 10", {busy, resp0_valid}); end
    total++; if ({alu_rd1, alu_rd2, alu_op} !== {32'd5, 32'd7, 4'd0}) begin bad++; $display("FAIL single_alu_drive: got %h %h %h want 5 7 0", alu_rd1, alu_rd2, alu_op); end
    tick();
    total++; if ({resp0_valid, resp1_valid} !== 2'b10) begin bad++; $display("FAIL single_latency: got %b want 10", {resp0_valid, resp1_valid}); end
    total++; if ({resp_data, resp_err} !== {32'd12, 1'b0}) begin bad++; $display("FAIL single_data: got %h/%b want 0000000c/0", resp_data, resp_err); end
    tick();
    m_count = m_count + 16'd1; m_last = 0;
    total++; if ({resp0_valid, busy, op_count} !== {2'b00, m_count}) begin bad++; $display("FAIL single_done: got %b%b %h want 00 %h", resp0_valid, busy, op_count, m_count); end
  endtask

  task automatic test_contention();
    int g[8]; int n = 0; int fn = 0; int f1 = 0;
    do_reset();
    req0_op = 4'd1; req0_a = 32'd100;    req0_b = 32'd1;
    req1_op = 4'd2; req1_a = 32'hFF00;   req1_b = 32'h0FF0;
    req0_valid = 1; req1_valid = 1; f_req0_valid = 1; f_req1_valid = 1;
    resp0_ready = 1; resp1_ready = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req0_ready && n < 8) begin g[n] = 0; n++; end
      if (req1_ready && n < 8) begin g[n] = 1; n++; end
      if (f_req0_ready) fn++;
      if (f_req1_ready) f1++;
      if (resp0_valid) begin
        total++; if (resp_data !== 32'd99) begin bad++; $display("FAIL rr_data0: got %h want 00000063", resp_data); end
      end
      if (resp1_valid) begin
        total++; if (resp_data !== 32'h00000F00) begin bad++; $display("FAIL rr_data1: got %h want 00000f00", resp_data); end
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0; f_req0_valid = 0; f_req1_valid = 0;
    total++; if (n != 4) begin bad++; $display("FAIL rr_grant_count: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      total++; if (g[i] != (i % 2)) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, g[i], i % 2); end
    end
    total++; if (fn != 4 || f1 != 0) begin bad++; $display("FAIL fp_grants: got r0=%0d r1=%0d want r0=4 r1=0", fn, f1); end
    total++; if (f_op_count !== 16'd4) begin bad++; $display("FAIL fp_count: got %h want 0004", f_op_count); end
    m_count = 16'd4; m_last = 1;
    total++; if (op_count !== m_count) begin bad++; $display("FAIL rr_count: got %h want %h", op_count, m_count); end
  endtask

  task automatic test_backpressure();
    resp1_ready = 0; resp0_ready = 0;
    issue(1, 4'd6, 32'h80000000, $urandom, 5'd4);
    tick();
    req0_valid = 1; resp0_ready = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if ({resp1_valid, resp0_valid, busy, req0_ready, req1_ready} !== 5'b10100) begin bad++; $display("FAIL bp_flags[%0d]: got %b want 10100", c, {resp1_valid, resp0_valid, busy, req0_ready, req1_ready}); end
      total++; if ({resp_data, resp_err} !== {32'hF8000000, 1'b0}) begin bad++; $display("FAIL bp_data[%0d]: got %h/%b want f8000000/0", c, resp_data, resp_err); end
      tick();
    end
    req0_valid = 0; resp1_ready = 1;
    tick();
    m_count = m_count + 16'd1; m_last = 1;
    total++; if ({resp1_valid, op_count} !== {1'b0, m_count}) begin bad++; $display("FAIL bp_done: got %b %h want 0 %h", resp1_valid, op_count, m_count); end
  endtask

  task automatic test_illegal();
    logic [3:0]  ops [4];
    logic [31:0] a, b, want;
    ops[0] = 4'd8; ops[1] = 4'd9; ops[2] = 4'd12; ops[3] = 4'd15;
    resp0_ready = 1; resp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom;
      want = (ops[k] == 4'd8 && $signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      issue(0, ops[k], a, b, 5'($urandom));
      tick();
      total++; if ({resp0_valid, resp_data, resp_err} !== {1'b1, want, ops[k] > 4'd8}) begin bad++; $display("FAIL illegal_op%0d: got %b %h %b want 1 %h %b", ops[k], resp0_valid, resp_data, resp_err, want, ops[k] > 4'd8); end
      tick();
      m_count = m_count + 16'd1; m_last = 0;
      total++; if (op_count !== m_count) begin bad++; $display("FAIL illegal_count%0d: got %h want %h", ops[k], op_count, m_count); end
    end
  endtask

  task automatic test_reset_in_resp();
    resp0_ready = 0;
    issue(0, 4'd3, $urandom, $urandom, 5'd0);
    tick();
    total++; if (resp0_valid !== 1'b1) begin bad++; $display("FAIL rir_pre: got %b want 1", resp0_valid); end
    rst = 1;
    tick();
    total++; if ({resp0_valid, busy, op_count} !== 18'd0) begin bad++; $display("FAIL rir_abandon: got %b%b %h want 00 0000", resp0_valid, busy, op_count); end
    rst = 0; m_count = 16'd0; m_last = 1;
    req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rir_grant: got %b want 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 0; req1_valid = 0;
    tick(); tick();
    m_count = 16'd1; m_last = 0;
    total++; if (op_count !== m_count) begin bad++; $display("FAIL rir_count: got %h want %h", op_count, m_count); end
  endtask

  // Transaction-level model: a granted op answers two edges later and completes on the owner's ready.
  task automatic test_random();
    bit inflight = 0; bit owner = 0; int age = 0;
    logic [31:0] exp_data; logic exp_err; logic e0, e1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = (cyc < 392) && ($urandom_range(0, 2) != 0);
      req1_valid = (cyc < 392) && ($urandom_range(0, 2) != 0);
      req0_op = 4'($urandom); req1_op = 4'($urandom);
      req0_a = $urandom; req1_a = $urandom; req0_b = $urandom; req1_b = $urandom;
      req0_shamt = 5'($urandom); req1_shamt = 5'($urandom);
      resp0_ready = (cyc >= 392) || ($urandom_range(0, 1) != 0);
      resp1_ready = (cyc >= 392) || ($urandom_range(0, 1) != 0);
      #1;
      e1 = !inflight && req1_valid && (!req0_valid || !m_last);
      e0 = !inflight && req0_valid && !e1;
      total++; if ({req0_ready, req1_ready, busy} !== {e0, e1, inflight}) begin bad++; $display("FAIL rand_ctrl@%0d: got %b want %b", cyc, {req0_ready, req1_ready, busy}, {e0, e1, inflight}); end
      total++; if ({resp0_valid, resp1_valid} !== {inflight && age >= 2 && !owner, inflight && age >= 2 && owner}) begin bad++; $display("FAIL rand_resp_valid@%0d: got %b owner %0d age %0d", cyc, {resp0_valid, resp1_valid}, owner, age); end
      total++; if (op_count !== m_count) begin bad++; $display("FAIL rand_count@%0d: got %h want %h", cyc, op_count, m_count); end
      if (inflight && age >= 2) begin
        total++; if ({resp_data, resp_err} !== {exp_data, exp_err}) begin bad++; $display("FAIL rand_data@%0d: got %h/%b want %h/%b", cyc, resp_data, resp_err, exp_data, exp_err); end
      end
      if (e0 || e1) begin
        inflight = 1; age = 0; owner = e1;
        exp_data = e1 ? alu_ref(req1_op, req1_a, req1_b, req1_shamt) : alu_ref(req0_op, req0_a, req0_b, req0_shamt);
        exp_err  = (e1 ? req1_op : req0_op) > 4'd8;
      end else if (inflight && age >= 2 && (owner ? resp1_ready : resp0_ready)) begin
        inflight = 0; m_count = m_count + 16'd1; m_last = owner;
      end
      tick();
      if (inflight) age++;
    end
    clear_inputs();
    total++; if (inflight || busy !== 1'b0) begin bad++; $display("FAIL rand_drain: busy got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    force dut.r_op_count = 16'hFFFF;
    tick();
    release dut.r_op_count;
    m_count = 16'hFFFF;
    tick();
    total++; if (op_count !== m_count) begin bad++; $display("FAIL wrap_preload: got %h want ffff", op_count); end
    resp1_ready = 1;
    issue(1, 4'd4, 32'h1, 32'h0, 5'd31);
    tick();
    total++; if (resp_data !== 32'h80000000) begin bad++; $display("FAIL wrap_data: got %h want 80000000", resp_data); end
    tick();
    m_count = m_count + 16'd1;
    total++; if (op_count !== 16'h0000 || m_count !== 16'h0000) begin bad++; $display("FAIL wrap_count: got %h want 0000", op_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_in_resp();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
